// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command codes, read-sequencer states,
// default timing and the user address field layout.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_BST       = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;

    typedef enum logic [3:0] {
        STATE_IDLE = 4'b0000,
        STATE_ACT  = 4'b0001,
        STATE_TRCD = 4'b0011,
        STATE_RD   = 4'b0010,
        STATE_TCL  = 4'b0100,
        STATE_DATA = 4'b0101,
        STATE_PRE  = 4'b0111,
        STATE_TRP  = 4'b0110,
        STATE_END  = 4'b1100
    } rd_state_e;

    localparam int TRCD_CLK_DEF    = 2;
    localparam int CAS_LATENCY_DEF = 3;
    localparam int TRP_CLK_DEF     = 2;

    localparam int ADDR_BANK_HI = 23;
    localparam int ADDR_BANK_LO = 22;
    localparam int ADDR_ROW_HI  = 21;
    localparam int ADDR_ROW_LO  = 9;
    localparam int ADDR_COL_HI  = 8;
    localparam int ADDR_COL_LO  = 0;

    localparam logic [9:0] BURST_MAX = 10'd512;

endpackage

// File: rtl/sdram_read.sv
// SDRAM read command sequencer: ACTIVE, READ full-page burst, BURST STOP,
// PRECHARGE, returning the burst one word per cycle qualified by rd_ack.
module sdram_read
    import sdram_pkg::*;
#(
    parameter int TRCD_CLK    = TRCD_CLK_DEF,
    parameter int CAS_LATENCY = CAS_LATENCY_DEF,
    parameter int TRP_CLK     = TRP_CLK_DEF
) (
    input  logic        rd_clk,
    input  logic        rd_rst_n,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [23:0] rd_addr,
    input  logic [9:0]  rd_bst_len,
    input  logic [15:0] rd_sdram_data,
    output logic        rd_ack,
    output logic        rd_end,
    output logic [15:0] rd_data,
    output logic [3:0]  rd_sdram_cmd,
    output logic [1:0]  rd_sdram_bank,
    output logic [12:0] rd_sdram_addr
);

    localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
    localparam logic [9:0] TCL_LAST  = 10'(CAS_LATENCY - 2);
    localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);
    localparam logic [9:0] CL        = 10'(CAS_LATENCY);

    rd_state_e   state;
    rd_state_e   state_next;
    logic [9:0]  cnt;
    logic [23:0] addr_lat;
    logic [9:0]  len_lat;
    logic        accept;
    logic        bst_hit;

    assign accept = init_end && rd_en && (rd_bst_len != 10'd0);

    // BURST STOP lands on cycle len after READ: inside TCL for short bursts,
    // otherwise at DATA count len-CL.
    assign bst_hit = ((state == STATE_TCL)  && (len_lat < CL)  && (cnt == len_lat - 10'd1)) ||
                     ((state == STATE_DATA) && (len_lat >= CL) && (cnt == len_lat - CL));

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state <= STATE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: if (accept)               state_next = STATE_ACT;
            STATE_ACT:                            state_next = STATE_TRCD;
            STATE_TRCD: if (cnt == TRCD_LAST)     state_next = STATE_RD;
            STATE_RD:                             state_next = STATE_TCL;
            STATE_TCL:  if (cnt == TCL_LAST)      state_next = STATE_DATA;
            STATE_DATA: if (cnt == len_lat - 10'd1) state_next = STATE_PRE;
            STATE_PRE:                            state_next = STATE_TRP;
            STATE_TRP:  if (cnt == TRP_LAST)      state_next = STATE_END;
            STATE_END:                            state_next = STATE_IDLE;
            default:                              state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        rd_sdram_cmd  = CMD_NOP;
        rd_sdram_bank = 2'b11;
        rd_sdram_addr = 13'h1fff;
        rd_end        = 1'b0;
        case (state)
            STATE_ACT: begin
                rd_sdram_cmd  = CMD_ACTIVE;
                rd_sdram_bank = addr_lat[ADDR_BANK_HI:ADDR_BANK_LO];
                rd_sdram_addr = addr_lat[ADDR_ROW_HI:ADDR_ROW_LO];
            end
            STATE_RD: begin
                rd_sdram_cmd  = CMD_READ;
                rd_sdram_bank = addr_lat[ADDR_BANK_HI:ADDR_BANK_LO];
                rd_sdram_addr = {4'b0000, addr_lat[ADDR_COL_HI:ADDR_COL_LO]};
            end
            STATE_TCL, STATE_DATA: begin
                if (bst_hit) rd_sdram_cmd = CMD_BST;
            end
            STATE_PRE: begin
                rd_sdram_cmd  = CMD_PRECHARGE;
                rd_sdram_bank = addr_lat[ADDR_BANK_HI:ADDR_BANK_LO];
                rd_sdram_addr = 13'h0400;
            end
            STATE_END: rd_end = 1'b1;
            default: ;
        endcase
    end

    // Single cycle counter, restarted on every state entry.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            cnt <= 10'd0;
        end else if ((state_next != state) || (state == STATE_IDLE)) begin
            cnt <= 10'd0;
        end else begin
            cnt <= cnt + 10'd1;
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            addr_lat <= 24'd0;
            len_lat  <= 10'd0;
        end else if ((state == STATE_IDLE) && accept) begin
            addr_lat <= rd_addr;
            len_lat  <= (rd_bst_len > BURST_MAX) ? BURST_MAX : rd_bst_len;
        end
    end

    // Pin data registered once; rd_ack follows DATA by one edge.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_ack  <= 1'b0;
            rd_data <= 16'd0;
        end else begin
            rd_ack <= (state == STATE_DATA);
            if (state == STATE_DATA) rd_data <= rd_sdram_data;
        end
    end

endmodule
